// File: rtl/uart_fifo_wr_arb.sv
// Two-requester round-robin write arbiter in front of a sync FIFO, with bursts capped at MAX_BURST beats.
// Optional per-requester saturating beat counters (stat0/stat1) are enabled with `define UART_FIFO_WR_ARB_STAT_EN.
module uart_fifo_wr_arb #(
  parameter int unsigned DATA_BIT  = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_BIT-1:0] req0_data,
  input  logic                req0_valid,
  input  logic                req0_last,
  output logic                req0_ready,
  input  logic [DATA_BIT-1:0] req1_data,
  input  logic                req1_valid,
  input  logic                req1_last,
  output logic                req1_ready,
  output logic [DATA_BIT-1:0] f_data,
  output logic                f_valid,
  input  logic                f_ready,
  output logic [1:0]          grant,
  output logic                busy
`ifdef UART_FIFO_WR_ARB_STAT_EN
  ,
  output logic [15:0]         stat0,
  output logic [15:0]         stat1
`endif
);

  // State encodings double as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_e;

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic       prio_q, prio_d;
  logic [3:0] cnt_q, cnt_d;

  logic       xfer0, xfer1;
  logic       sel1, cur_valid, cur_last, oth_valid, xfer, rel;
  logic [3:0] cnt_inc;

  assign xfer0 = (state_q == GRANT0) && req0_valid && f_ready;
  assign xfer1 = (state_q == GRANT1) && req1_valid && f_ready;

  assign grant = state_q;
  assign busy  = |state_q;

  always_comb begin
    f_data     = '0;
    f_valid    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      GRANT0: begin
        f_data     = req0_data;
        f_valid    = req0_valid;
        req0_ready = f_ready;
      end
      GRANT1: begin
        f_data     = req1_data;
        f_valid    = req1_valid;
        req1_ready = f_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    sel1      = (state_q == GRANT1);
    cur_valid = sel1 ? req1_valid : req0_valid;
    cur_last  = sel1 ? req1_last  : req0_last;
    oth_valid = sel1 ? req0_valid : req1_valid;
    xfer      = xfer0 | xfer1;
    cnt_inc   = cnt_q + 4'd1;
    rel       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0_valid && req1_valid) state_d = prio_q ? GRANT1 : GRANT0;
        else if (req0_valid)          state_d = GRANT0;
        else if (req1_valid)          state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (xfer) cnt_d = cnt_inc;
        rel = (xfer && (cur_last || cnt_inc == MAX_BURST_C)) || !cur_valid;
        if (rel) begin
          cnt_d  = '0;
          prio_d = !sel1;
          // cur_valid high here means the release came from a transfer, not a valid drop.
          if (oth_valid)      state_d = sel1 ? GRANT0 : GRANT1;
          else if (cur_valid) state_d = state_q;
          else                state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef UART_FIFO_WR_ARB_STAT_EN
  logic [15:0] stat0_q, stat0_d, stat1_q, stat1_d;

  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (xfer0 && stat0_q != '1) stat0_d = stat0_q + 16'd1;
    if (xfer1 && stat1_q != '1) stat1_d = stat1_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign stat0 = stat0_q;
  assign stat1 = stat1_q;
`endif

endmodule

// File: tb/tb_uart_fifo_wr_arb.sv
// Directed-vector bench for uart_fifo_wr_arb (DATA_BIT=8, MAX_BURST=4).
// Define UART_FIFO_WR_ARB_STAT_EN for both files to include the statistics scenario.
module tb_uart_fifo_wr_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req0_data, req1_data, f_data;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic       f_valid, f_ready, busy;
  logic [1:0] grant;
`ifdef UART_FIFO_WR_ARB_STAT_EN
  logic [15:0] stat0, stat1;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  uart_fifo_wr_arb #(.DATA_BIT(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .grant(grant), .busy(busy)
`ifdef UART_FIFO_WR_ARB_STAT_EN
    , .stat0(stat0), .stat1(stat1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    req0_data = '0; req0_valid = 1'b0; req0_last = 1'b0;
    req1_data = '0; req1_valid = 1'b0; req1_last = 1'b0;
    f_ready = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; f_ready = 1'b1; req0_data = 8'hAA; req1_data = 8'hBB;
    tick(); settle();
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", grant); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (f_valid !== 1'b0) begin errors++; $display("FAIL rst_f_valid got %b want 0", f_valid); end
    vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b%b want 00", req0_ready, req1_ready); end
    vectors++; if (f_data !== 8'h00) begin errors++; $display("FAIL rst_f_data got %h want 00", f_data); end
    reset = 1'b0;
    tick(); settle();
    vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL rst_first_grant got %b want 01", grant); end
  endtask

  task automatic test_single();
    apply_reset();
    req0_valid = 1'b1; req0_data = 8'd1; f_ready = 1'b1;
    settle();
    vectors++; if (grant !== 2'b00 || f_valid !== 1'b0) begin errors++; $display("FAIL single_idle got grant=%b f_valid=%b want 00/0", grant, f_valid); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      req0_data = 8'(k);
      req0_last = (k == 3);
      settle();
      vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant k=%0d got %b want 01", k, grant); end
      vectors++; if (f_valid !== 1'b1 || f_data !== 8'(k)) begin errors++; $display("FAIL single_write k=%0d got v=%b d=%h want 1/%h", k, f_valid, f_data, 8'(k)); end
      vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready k=%0d got %b%b want 10", k, req0_ready, req1_ready); end
    end
    tick();
    req0_valid = 1'b0; req0_last = 1'b0;
    settle();
    vectors++; if (f_valid !== 1'b0) begin errors++; $display("FAIL single_after_last_valid got %b want 0", f_valid); end
    tick(); settle();
    vectors++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL single_idle_end got grant=%b busy=%b want 00/0", grant, busy); end
  endtask

  task automatic test_burst_cap();
    int n0, n1;
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    apply_reset();
    n0 = 0; n1 = 0;
    req0_valid = 1'b1; req1_valid = 1'b1; f_ready = 1'b1;
    req0_data = 8'h10; req1_data = 8'h20;
    settle();
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL burst_idle got %b want 00", grant); end
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_g = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
      req0_data = 8'(8'h10 + n0);
      req1_data = 8'(8'h20 + n1);
      exp_d = (exp_g == 2'b01) ? 8'(8'h10 + n0) : 8'(8'h20 + n1);
      settle();
      vectors++; if (grant !== exp_g) begin errors++; $display("FAIL burst_grant i=%0d got %b want %b", i, grant, exp_g); end
      vectors++; if (f_valid !== 1'b1 || f_data !== exp_d) begin errors++; $display("FAIL burst_data i=%0d got v=%b d=%h want 1/%h", i, f_valid, f_data, exp_d); end
      if (exp_g == 2'b01) n0++; else n1++;
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req0_valid = 1'b1; req0_data = 8'h30; req1_valid = 1'b1; req1_data = 8'h60; f_ready = 1'b1;
    tick(); settle();
    vectors++; if (grant !== 2'b01 || f_data !== 8'h30) begin errors++; $display("FAIL bp_start got g=%b d=%h want 01/30", grant, f_data); end
    tick();
    req0_data = 8'h31; f_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      settle();
      vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL bp_hold s=%0d got %b want 01", s, grant); end
      vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready s=%0d got %b%b want 00", s, req0_ready, req1_ready); end
      vectors++; if (f_valid !== 1'b1 || f_data !== 8'h31) begin errors++; $display("FAIL bp_word s=%0d got v=%b d=%h want 1/31", s, f_valid, f_data); end
      tick();
    end
    f_ready = 1'b1;
    settle();
    vectors++; if (grant !== 2'b01 || req0_ready !== 1'b1 || f_data !== 8'h31) begin errors++; $display("FAIL bp_resume got g=%b r=%b d=%h want 01/1/31", grant, req0_ready, f_data); end
    tick(); req0_data = 8'h32; settle();
    vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL bp_beat3 got %b want 01", grant); end
    tick(); req0_data = 8'h33; settle();
    vectors++; if (grant !== 2'b01 || f_data !== 8'h33) begin errors++; $display("FAIL bp_beat4 got g=%b d=%h want 01/33", grant, f_data); end
    tick(); settle();
    vectors++; if (grant !== 2'b10 || f_data !== 8'h60) begin errors++; $display("FAIL bp_handover got g=%b d=%h want 10/60", grant, f_data); end
  endtask

  task automatic test_valid_drop();
    apply_reset();
    req1_valid = 1'b1; req1_data = 8'h55; f_ready = 1'b1;
    tick(); settle();
    vectors++; if (grant !== 2'b10 || f_data !== 8'h55) begin errors++; $display("FAIL drop_grant got g=%b d=%h want 10/55", grant, f_data); end
    vectors++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL drop_ready got %b%b want 01", req0_ready, req1_ready); end
    tick();
    req1_valid = 1'b0;
    settle();
    vectors++; if (grant !== 2'b10 || f_valid !== 1'b0) begin errors++; $display("FAIL drop_hold got g=%b v=%b want 10/0", grant, f_valid); end
    tick(); settle();
    vectors++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL drop_idle got g=%b busy=%b want 00/0", grant, busy); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick(); settle();
    vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL drop_pointer got %b want 01", grant); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req0_valid = 1'b1; req0_data = 8'h40; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h50; f_ready = 1'b1;
    settle();
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_idle got %b want 00", grant); end
    tick(); settle();
    vectors++; if (grant !== 2'b01 || f_data !== 8'h40) begin errors++; $display("FAIL rmid_g0 got g=%b d=%h want 01/40", grant, f_data); end
    tick();
    req0_valid = 1'b0; req0_last = 1'b0;
    settle();
    vectors++; if (grant !== 2'b10 || f_data !== 8'h50) begin errors++; $display("FAIL rmid_g1 got g=%b d=%h want 10/50", grant, f_data); end
    tick(); req1_data = 8'h51; settle();
    vectors++; if (grant !== 2'b10 || f_data !== 8'h51) begin errors++; $display("FAIL rmid_beat2 got g=%b d=%h want 10/51", grant, f_data); end
    tick(); req1_data = 8'h52; reset = 1'b1; settle();
    vectors++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rmid_abort got g=%b busy=%b want 00/0", grant, busy); end
    vectors++; if (f_valid !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_abort_hs got v=%b r1=%b want 0/0", f_valid, req1_ready); end
    tick();
    reset = 1'b0; req0_valid = 1'b1;
    settle();
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_post_idle got %b want 00", grant); end
    tick(); settle();
    vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_pointer got %b want 01", grant); end
  endtask

`ifdef UART_FIFO_WR_ARB_STAT_EN
  task automatic test_stat();
    apply_reset();
    req0_valid = 1'b1; f_ready = 1'b1;
    tick();
    repeat (20) tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b1;
    tick();
    repeat (7) tick();
    req1_valid = 1'b0;
    tick(); tick(); settle();
    vectors++; if (stat0 !== 16'd20) begin errors++; $display("FAIL stat0_count got %0d want 20", stat0); end
    vectors++; if (stat1 !== 16'd7) begin errors++; $display("FAIL stat1_count got %0d want 7", stat1); end
    force dut.stat0_q = 16'hFFFF;
    #1;
    release dut.stat0_q;
    req0_valid = 1'b1;
    tick(); tick();
    req0_valid = 1'b0;
    settle();
    vectors++; if (stat0 !== 16'hFFFF) begin errors++; $display("FAIL stat0_saturate got %h want ffff", stat0); end
  endtask
`endif

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_single();
    test_burst_cap();
    test_backpressure();
    test_valid_drop();
    test_reset_mid();
`ifdef UART_FIFO_WR_ARB_STAT_EN
    test_stat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_wr_arb.md
UART_FIFO_WR_ARB -- requirements
Module: uart_fifo_wr_arb

Interface
REQ-001 Parameter DATA_BIT, default 8: width of each data word.
REQ-002 Parameter MAX_BURST, default 4, range 1..15: maximum beats per grant.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0_data  input  DATA_BIT  requester 0 write word.
REQ-006 req0_valid  input  1  requester 0 word present.
REQ-007 req0_last  input  1  requester 0 word ends its burst.
REQ-008 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-009 req1_data, req1_valid, req1_last, req1_ready: same widths, directions and meanings as REQ-005..008, for requester 1.
REQ-010 f_data  output  DATA_BIT  word to the sync FIFO write port.
REQ-011 f_valid  output  1  FIFO write request.
REQ-012 f_ready  input  1  FIFO not full; a beat transfers when f_valid and f_ready are both 1.
REQ-013 grant  output  2  one-hot registered grant; 2'b00 when idle.
REQ-014 busy  output  1  high in any GRANT state.

Function
REQ-015 The state machine SHALL have states IDLE, GRANT0 and GRANT1, encoded in registers.
REQ-016 The arbiter SHALL hold a round-robin priority pointer: req0 has priority after reset, and the requester not served last has priority after each release.
REQ-017 In IDLE, with any reqN_valid=1, the arbiter SHALL move next cycle to GRANTN of the valid requester; if both are valid, the pointer decides.
REQ-018 In GRANTN, the path is combinational with zero latency: f_data=reqN_data, f_valid=reqN_valid, reqN_ready=f_ready; the other requester's ready SHALL be 0.
REQ-019 In IDLE, f_valid, req0_ready and req1_ready SHALL be 0, and f_data SHALL be 0.
REQ-020 A 4-bit beat counter SHALL clear on grant entry and increment on each transferred beat.
REQ-021 Release SHALL occur at the end of any GRANTN cycle that meets one of these conditions:
- a beat transfers with reqN_last=1;
- a beat transfers and the counter reaches MAX_BURST;
- reqN_valid=0.
REQ-022 On release, the next state SHALL be chosen as follows:
- GRANT of the other requester if its valid is 1;
- otherwise GRANTN again if reqN_valid=1 and the release was not caused by reqN_valid=0;
- otherwise IDLE.
REQ-023 With f_ready=0, the grant SHALL be held, the counter SHALL not change, and no timeout applies.
REQ-024 The grant SHALL never change in a cycle in which no release condition holds, so bursts are never interleaved.
REQ-025 busy SHALL be 1 exactly when grant is nonzero.

Reset
REQ-026 While reset=1, the following SHALL hold:
- state=IDLE, grant=2'b00, busy=0;
- beat counter=0;
- priority pointer selects req0;
- all ready outputs and f_valid are 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately; a word presented in that cycle is not transferred.
REQ-028 The first grant SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-029 With macro UART_FIFO_WR_ARB_STAT_EN defined, the block SHALL have two extra ports:
- stat0 output 16: saturating count of requester 0 transferred beats;
- stat1 output 16: saturating count of requester 1 transferred beats.
Both counts clear on reset and hold at 16'hFFFF.
REQ-030 Without UART_FIFO_WR_ARB_STAT_EN, stat0 and stat1 and their logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Single requester: req0 sends words 1..3, last on 3, f_ready=1 -> grant=01 one cycle after valid; 3 FIFO writes in consecutive cycles; then IDLE.
- Burst cap: both valid continuously, no last, MAX_BURST=4 -> beats alternate in groups 4 from req0, 4 from req1, 4 from req0; no idle cycle between groups.
- Backpressure: f_ready=0 for 5 cycles mid-burst -> grant held, counter frozen, no ready pulses; the burst resumes with the next word unchanged.
- Valid drop: req1 granted, drops valid after 1 beat, req0 idle -> state IDLE next cycle; pointer favours req0.
- Reset mid-burst: reset pulsed after beat 2 of 4 -> grant=00 and f_valid=0 immediately; pointer on req0 after release of reset.
- STAT_EN build: 20 beats from req0 and 7 from req1 -> stat0=20, stat1=7; a forced value of 16'hFFFF plus one beat stays at 16'hFFFF.
